vec_loader: RTL and testbench

- Upstream feeder for the dot-product datapath.
- Accepts a stream of (a, b) operand pairs over a valid/ready handshake and writes them to sequential addresses of the two operand block RAMs (RAM A, RAM B) with ram_init asserted.
- Publishes the element count n, pulses start to the dot-product engine, then waits for its done_flag before accepting a new vector.
- Replaces the external ram_init / a_ram_in / b_ram_in / addr drivers at the top level.

---
 rtl/vec_pkg.sv | 16 +
 rtl/vec_loader.sv | 118 +++++++++++
 tb/tb_vec_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector loader that feeds the
// dot-product engine's operand RAMs.
package vec_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RUN
  } ld_state_t;

endpackage

// File: rtl/vec_loader.sv
// Streams (a, b) operand pairs into RAM A / RAM B, publishes the
// element count, launches the dot product and waits for its done flag.
module vec_loader
  import vec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  input  logic              s_last,
  output logic              ram_init,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] b_wdata,
  output logic [CNT_W-1:0]  n_out,
  output logic              start,
  input  logic              dot_done,
  output logic              busy,
  output logic              overflow
);

  localparam int CAP = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(CAP - 1);

  ld_state_t         state, state_d;
  logic              fin, fin_d;
  logic [ADDR_W:0]   cnt, cnt_d;
  logic              ram_init_d, start_d, ovf_d;
  logic              ready_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] a_d, b_d;
  logic [CNT_W-1:0]  n_d;
  logic              acc, at_cap;

  assign acc    = s_valid & s_ready;
  assign at_cap = (cnt == LAST_IDX);

  always_comb begin
    state_d    = state;
    fin_d      = fin;
    cnt_d      = cnt;
    ram_init_d = 1'b0;
    addr_d     = ram_addr;
    a_d        = a_wdata;
    b_d        = b_wdata;
    n_d        = n_out;
    start_d    = 1'b0;
    ovf_d      = overflow;
    unique case (state)
      IDLE, LOAD: begin
        // fin marks the write cycle of the closing beat
        if (fin) begin
          state_d = START;
          start_d = 1'b1;
          n_d     = CNT_W'(cnt);
          fin_d   = 1'b0;
        end else if (acc) begin
          state_d    = LOAD;
          ram_init_d = 1'b1;
          addr_d     = cnt[ADDR_W-1:0];
          a_d        = s_a;
          b_d        = s_b;
          cnt_d      = cnt + 1'b1;
          if (state == IDLE) ovf_d = 1'b0;
          if (s_last || at_cap) fin_d = 1'b1;
          if (at_cap && !s_last) ovf_d = 1'b1;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (dot_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
    ready_d = (state_d == IDLE) ||
              (state_d == LOAD && !fin_d);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fin      <= 1'b0;
      cnt      <= '0;
      s_ready  <= 1'b1;
      ram_init <= 1'b0;
      ram_addr <= '0;
      a_wdata  <= '0;
      b_wdata  <= '0;
      n_out    <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      fin      <= fin_d;
      cnt      <= cnt_d;
      s_ready  <= ready_d;
      ram_init <= ram_init_d;
      ram_addr <= addr_d;
      a_wdata  <= a_d;
      b_wdata  <= b_d;
      n_out    <= n_d;
      start    <= start_d;
      busy     <= busy_d;
      overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vec_loader.sv
// Bench for vec_loader: directed vectors, a queue model of the
// expected RAM writes and a per-cycle compare process.
module tb_vec_loader;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int CW = 32;
  localparam int DEPTH = 8;

  logic          clk = 0;
  logic          rst = 1;
  logic          s_valid = 0;
  logic          s_ready;
  logic [DW-1:0] s_a = 0;
  logic [DW-1:0] s_b = 0;
  logic          s_last = 0;
  logic          ram_init;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] a_wdata;
  logic [DW-1:0] b_wdata;
  logic [CW-1:0] n_out;
  logic          start;
  logic          dot_done = 0;
  logic          busy;
  logic          overflow;

  vec_loader #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .ram_init(ram_init), .ram_addr(ram_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata),
    .n_out(n_out), .start(start),
    .dot_done(dot_done), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } wr_t;

  wr_t exp_q[$];
  int  m_cnt = 0;
  int  exp_n = 0;
  int  checks = 0;
  int  errors = 0;
  bit  prev_start = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer one beat; the model records it only if it was accepted.
  task automatic send(input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input logic last,
                      input int lim,
                      output bit ok);
    s_valid = 1; s_a = a; s_b = b; s_last = last;
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
    end
    #1;
    s_valid = 0; s_last = 0;
    if (ok) begin
      exp_q.push_back('{addr: AW'(m_cnt), a: a, b: b});
      m_cnt++;
      if (last || m_cnt == DEPTH) exp_n = m_cnt;
    end
  endtask

  task automatic beat(input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input logic last);
    bit ok;
    send(a, b, last, 200, ok);
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic finish_run();
    repeat (3) @(posedge clk);
    #1 dot_done = 1;
    @(posedge clk);
    #1 dot_done = 0;
    m_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_init) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 1, 0);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 64'(ram_addr), 64'(w.addr));
          chk("wr_a", 64'(a_wdata), 64'(w.a));
          chk("wr_b", 64'(b_wdata), 64'(w.b));
        end
      end
      if (start) begin
        chk("start_n", 64'(n_out), 64'(exp_n));
        chk("start_pending_wr", 64'(exp_q.size()), 0);
        chk("start_one_cycle", 64'(prev_start), 0);
      end
      prev_start = start;
    end
  end

  initial begin
    bit ok;
    int bad;

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", s_ready, 1);
    chk("rst_init", ram_init, 0);
    chk("rst_addr", 64'(ram_addr), 0);
    chk("rst_a", 64'(a_wdata), 0);
    chk("rst_n", 64'(n_out), 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);

    // 4 elements back to back
    @(posedge clk); #1;
    beat(1, 5, 0); beat(2, 6, 0);
    beat(3, 7, 0); beat(4, 8, 1);
    chk("model_n4", 64'(exp_n), 4);
    @(negedge clk);
    chk("v4_wr_cycle_start", start, 0);
    chk("v4_ready_low", s_ready, 0);
    @(negedge clk);
    chk("v4_start", start, 1);
    chk("v4_n", 64'(n_out), 4);
    dot_done = 1;
    @(posedge clk); #1 dot_done = 0;
    @(negedge clk);
    chk("v4_done_in_start_ignored", busy, 1);
    chk("v4_run_ready", s_ready, 0);
    finish_run();
    @(negedge clk);
    chk("v4_idle_ready", s_ready, 1);
    chk("v4_n_held", 64'(n_out), 4);

    // bubbles between beats
    @(posedge clk); #1;
    beat(32'h11, 32'h21, 0);
    @(posedge clk); #1;
    beat(32'h12, 32'h22, 0);
    @(posedge clk); #1;
    beat(32'h13, 32'h23, 1);
    repeat (2) @(negedge clk);
    chk("bub_n", 64'(n_out), 3);
    finish_run();

    // single element, then a long RUN wait
    @(posedge clk); #1;
    beat(9, 3, 1);
    @(negedge clk);
    chk("one_wr_start", start, 0);
    @(negedge clk);
    chk("one_start", start, 1);
    chk("one_n", 64'(n_out), 1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("run_wait_bad_cycles", 64'(bad), 0);
    dot_done = 1;
    @(posedge clk); #1 dot_done = 0;
    m_cnt = 0;
    @(negedge clk);
    chk("done_ready", s_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_n_held", 64'(n_out), 1);

    // overflow: DEPTH beats without last
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++)
      beat(32'h100 + i, 32'h200 + i, 0);
    chk("model_ovf_n", 64'(exp_n), 8);
    send(32'hdead, 32'hbeef, 0, 20, ok);
    chk("ovf_backpressure", 64'(ok), 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_n", 64'(n_out), 8);
    finish_run();

    // reset mid-load after 3 beats
    @(posedge clk); #1;
    beat(31, 41, 0);
    @(negedge clk);
    chk("ovf_cleared", overflow, 0);
    @(posedge clk); #1;
    beat(32, 42, 0); beat(33, 43, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_q.delete();
    m_cnt = 0;
    @(negedge clk);
    chk("mid_rst_init", ram_init, 0);
    chk("mid_rst_n", 64'(n_out), 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    beat(51, 61, 0); beat(52, 62, 1);
    repeat (2) @(negedge clk);
    chk("post_rst_n", 64'(n_out), 2);
    finish_run();
    repeat (2) @(negedge clk);
    chk("end_queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
